fsl_ring_fifo: RTL and testbench

- Synchronous first-word-fall-through (FWFT) FIFO, 160-bit words by default.
- Used as the FSL ring-loopback buffer, and as the storage core of the FSL input FIFO.
- Provides full, empty and programmable-full flags. prog_full gives upstream pipelines early back-pressure before the FIFO fills.

---
 rtl/fsl_pkg.sv | 13 +
 rtl/fsl_fifo_ram.sv | 26 ++
 rtl/fsl_ring_fifo.sv | 98 +++++++++
 tb/tb_fsl_ring_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fsl_pkg.sv
// Shared constants and helpers for the FSL ring/input FIFO blocks.
package fsl_pkg;

  localparam int FSL_WORD_W           = 160;
  localparam int FSL_RING_DEPTH       = 16;
  localparam int FSL_PROG_FULL_MARGIN = 2;

  // Pointer width for a power-of-two depth; never returns less than 1.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fsl_fifo_ram.sv
// WIDTH x DEPTH simple dual-port storage: registered write port, combinational read port
// so the word at the read pointer is visible the cycle after it was written (FWFT).
module fsl_fifo_ram #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsl_ring_fifo.sv
// First-word-fall-through FIFO with registered full/empty/prog_full flags and occupancy count.
// Optional FSL_FIFO_STATUS_EN adds one-cycle overflow/underflow pulse outputs.
module fsl_ring_fifo
  import fsl_pkg::*;
#(
  parameter int WIDTH            = FSL_WORD_W,
  parameter int DEPTH            = FSL_RING_DEPTH,
  parameter int PROG_FULL_THRESH = DEPTH - FSL_PROG_FULL_MARGIN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic                    prog_full,
  output logic [ptr_w(DEPTH):0]   data_count
`ifdef FSL_FIFO_STATUS_EN
  ,
  output logic                    overflow,
  output logic                    underflow
`endif
);

  localparam int AW    = ptr_w(DEPTH);
  localparam int CNT_W = AW + 1;

  // Handshake: a write is taken on an edge where wr_en=1 and full=0 (full is the
  // inverse of ready); a read is taken where rd_en=1 and empty=0 (empty is the
  // inverse of valid). Requests outside those conditions are dropped, never queued.
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_acc;
  logic             rd_acc;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are derived from the next count so they stay aligned with data_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      prog_full <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CNT_W'(DEPTH));
      prog_full <= (count_nxt >= CNT_W'(PROG_FULL_THRESH));
    end
  end

  assign data_count = count;

`ifdef FSL_FIFO_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end
`endif

  fsl_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_fsl_ring_fifo.sv
// Directed scoreboard bench for fsl_ring_fifo (default parameters; FSL_FIFO_STATUS_EN optional).
module tb_fsl_ring_fifo;

  localparam int W     = 160;
  localparam int DEPTH = 16;
  localparam int PFT   = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         full;
  logic         empty;
  logic         prog_full;
  logic [4:0]   data_count;
`ifdef FSL_FIFO_STATUS_EN
  logic         overflow;
  logic         underflow;
`endif

  int errors = 0;
  int checks = 0;
  int m_cnt  = 0;
  logic [W-1:0] exp_q[$];

  fsl_ring_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .prog_full  (prog_full),
    .data_count (data_count)
`ifdef FSL_FIFO_STATUS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input logic exp_ov, input logic exp_un);
    check("data_count", W'(data_count), W'(m_cnt));
    check("empty", W'(empty), W'(m_cnt == 0));
    check("full", W'(full), W'(m_cnt == DEPTH));
    check("prog_full", W'(prog_full), W'(m_cnt >= PFT));
`ifdef FSL_FIFO_STATUS_EN
    check("overflow", W'(overflow), W'(exp_ov));
    check("underflow", W'(underflow), W'(exp_un));
`else
    if (exp_ov === 1'bx || exp_un === 1'bx) $display("unexpected unknown status");
`endif
  endtask

  // driver: one clock cycle of stimulus, called right after an active edge
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
    logic wr_ok, rd_ok, ov, un;
    wr_en = w; din = d; rd_en = r;
    wr_ok = w && (m_cnt < DEPTH);
    rd_ok = r && (m_cnt > 0);
    ov = w && !wr_ok;
    un = r && (m_cnt == 0);
    if (wr_ok) exp_q.push_back(d);
    @(posedge clk); #1;
    m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    wr_en = 1'b0; rd_en = 1'b0;
    check_flags(ov, un);
  endtask

  task automatic do_reset(input int n, input logic w);
    rst = 1'b1; wr_en = w; din = '1; rd_en = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0;
    check_flags(1'b0, 1'b0);
  endtask

  // monitor: head must match scoreboard whenever dout is valid; pop on accepted read
  always @(negedge clk) begin
    if (!rst && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head: dout %0h valid with no word expected", dout);
      end else begin
        check("head", dout, exp_q[0]);
        if (rd_en) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

    // 1: reset then idle, reads on empty are ignored
    do_reset(2, 1'b0);
    check("rst_cnt", W'(data_count), W'(0));
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    check("idle_empty", W'(empty), W'(1));

    // 2: single-word fall-through
    cyc(1'b1, 160'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF, 1'b0);
    check("fwft_dout", dout, 160'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF);
    check("fwft_empty", W'(empty), W'(0));
    cyc(1'b0, '0, 1'b1);
    check("pop_empty", W'(empty), W'(1));

    // 3: fill to full, overflow write dropped, read back in order
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, W'(i), 1'b0);
      if (i == 13) check("pf_13", W'(prog_full), W'(0));
      if (i == 14) check("pf_14", W'(prog_full), W'(1));
    end
    check("full_16", W'(full), W'(1));
    cyc(1'b1, W'(99), 1'b0);
    check("drop_cnt", W'(data_count), W'(16));
    for (int i = 1; i <= 16; i++) begin
      check("rd_order", dout, W'(i));
      cyc(1'b0, '0, 1'b1);
    end
    check("drained", W'(empty), W'(1));

    // 4: steady-state simultaneous read/write across pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(100 + i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, W'(200 + i), 1'b1);
    check("steady_cnt", W'(data_count), W'(5));
    check("steady_head", dout, W'(215));

    // 5: at full, read pops and write is dropped
    for (int i = 0; i < 11; i++) cyc(1'b1, W'(300 + i), 1'b0);
    check("full_again", W'(full), W'(1));
    cyc(1'b1, W'(999), 1'b1);
    check("full_rw_cnt", W'(data_count), W'(15));
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    check("seven", W'(data_count), W'(7));

    // 6: reset mid-operation with a write pending
    do_reset(1, 1'b1);
    check("mid_rst_empty", W'(empty), W'(1));
    cyc(1'b1, W'(160'h5A5A), 1'b0);
    check("post_rst_dout", dout, W'(160'h5A5A));
    check("post_rst_cnt", W'(data_count), W'(1));
    cyc(1'b0, '0, 1'b1);
    check("final_empty", W'(empty), W'(1));
    check("sb_empty", W'(exp_q.size()), W'(0));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
